// File: rtl/leve1_pkg.sv
// Shared types and constants for the LEVE1 fetch stage.
package leve1_pkg;

  localparam int unsigned       LEVE1_XLEN     = 32;
  localparam logic [LEVE1_XLEN-1:0] LEVE1_RESET_PC = 32'h8000_0000;
  localparam logic [31:0]       NOP_INSTR      = 32'h0000_0013;

  typedef struct packed {
    logic [LEVE1_XLEN-1:0] pc;
    logic [31:0]           instr;
  } fetch_entry_t;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } if_state_e;

endpackage

// File: rtl/leve1_fifo.sv
// Small synchronous FIFO of fetched instructions; flush wins over push,
// head is read straight from storage (no write-through bypass).
module leve1_fifo import leve1_pkg::*; #(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  entry_t                       push_data_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output entry_t                       head_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/leve1_if.sv
// LEVE1 instruction-fetch stage: PC owner, credit-limited imem requester, IF->ID producer.
// Optional counters PERF_FETCH/PERF_DROP are built when LEVE1_IF_PERF_EN is defined.
module leve1_if import leve1_pkg::*; #(
  parameter int unsigned      XLEN     = LEVE1_XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = LEVE1_RESET_PC,
  parameter int unsigned      DEPTH    = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            REDIRECT,
  input  logic [XLEN-1:0] REDIRECT_PC,
  output logic            IMEM_REQ_VALID,
  input  logic            IMEM_REQ_READY,
  output logic [XLEN-1:0] IMEM_REQ_ADDR,
  input  logic            IMEM_RSP_VALID,
  input  logic [31:0]     IMEM_RSP_DATA,
  output logic            IF_VALID,
  input  logic            IF_READY,
  output logic [XLEN-1:0] IF_PC,
  output logic [31:0]     IF_INSTR
`ifdef LEVE1_IF_PERF_EN
  ,
  output logic [XLEN-1:0] PERF_FETCH,
  output logic [XLEN-1:0] PERF_DROP
`endif
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  if_state_e       state_q, state_d;
  logic            run_c;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

  logic            credit_ok_c, req_hs_c, rsp_drop_c, push_c, pop_c;
  logic [XLEN-1:0] redirect_pc_c;
  logic            fifo_full_unused, fifo_empty;
  logic [CW-1:0]   fifo_count;
  fetch_entry_t    fifo_head, push_entry_c;
  logic            unused_redirect_lsb;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= ST_BOOT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_BOOT) state_d = ST_RUN;
  end

  always_comb begin
    run_c = 1'b0;
    if (state_q == ST_RUN) run_c = 1'b1;
  end

  // Credit uses registered counts only, so a same-cycle pop never frees a slot early.
  assign credit_ok_c    = ({1'b0, outstanding_q} + {1'b0, fifo_count}) < (CW+1)'(DEPTH);
  assign IMEM_REQ_VALID = run_c && !REDIRECT && credit_ok_c;
  assign IMEM_REQ_ADDR  = req_pc_q;
  assign req_hs_c       = IMEM_REQ_VALID && IMEM_REQ_READY;

  assign rsp_drop_c     = IMEM_RSP_VALID && (REDIRECT || (drop_cnt_q != '0));
  assign push_c         = IMEM_RSP_VALID && !rsp_drop_c;
  assign push_entry_c   = '{pc: rsp_pc_q, instr: IMEM_RSP_DATA};

  assign IF_VALID       = !fifo_empty && !REDIRECT;
  assign pop_c          = IF_VALID && IF_READY;
  assign IF_PC          = fifo_head.pc;
  assign IF_INSTR       = fifo_head.instr;

  assign redirect_pc_c       = {REDIRECT_PC[XLEN-1:2], 2'b00};
  assign unused_redirect_lsb = ^REDIRECT_PC[1:0];

  always_comb begin
    req_pc_d      = req_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q + CW'(req_hs_c) - CW'(IMEM_RSP_VALID);
    drop_cnt_d    = drop_cnt_q;
    if (REDIRECT) begin
      req_pc_d   = redirect_pc_c;
      rsp_pc_d   = redirect_pc_c;
      drop_cnt_d = outstanding_d;
    end else begin
      if (req_hs_c) req_pc_d = req_pc_q + XLEN'(4);
      if (push_c)   rsp_pc_d = rsp_pc_q + XLEN'(4);
      if (rsp_drop_c) drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      req_pc_q      <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      req_pc_q      <= req_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  leve1_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk_i       (CLK),
    .rst_i       (RST),
    .push_i      (push_c),
    .push_data_i (push_entry_c),
    .pop_i       (pop_c),
    .flush_i     (REDIRECT),
    .full_o      (fifo_full_unused),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count),
    .head_o      (fifo_head)
  );

`ifdef LEVE1_IF_PERF_EN
  logic [XLEN-1:0] perf_fetch_q, perf_fetch_d;
  logic [XLEN-1:0] perf_drop_q, perf_drop_d;
  logic [CW-1:0]   drop_inc_c;
  logic [XLEN:0]   drop_sum_c;

  // Drops count discarded responses plus entries thrown away by a flush; both saturate.
  always_comb begin
    perf_fetch_d = perf_fetch_q;
    if (pop_c && (perf_fetch_q != '1)) perf_fetch_d = perf_fetch_q + XLEN'(1);
    drop_inc_c  = CW'(rsp_drop_c) + (REDIRECT ? fifo_count : '0);
    drop_sum_c  = {1'b0, perf_drop_q} + (XLEN+1)'(drop_inc_c);
    perf_drop_d = drop_sum_c[XLEN] ? '1 : drop_sum_c[XLEN-1:0];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      perf_fetch_q <= '0;
      perf_drop_q  <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_drop_q  <= perf_drop_d;
    end
  end

  assign PERF_FETCH = perf_fetch_q;
  assign PERF_DROP  = perf_drop_q;
`endif

endmodule

// File: tb/tb_leve1_if.sv
// Directed bench for leve1_if: boot, streaming, backpressure, redirects, PC wrap.
module tb_leve1_if;
  import leve1_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic        IMEM_REQ_VALID;
  logic        IMEM_REQ_READY;
  logic [31:0] IMEM_REQ_ADDR;
  logic        IMEM_RSP_VALID;
  logic [31:0] IMEM_RSP_DATA;
  logic        IF_VALID;
  logic        IF_READY;
  logic [31:0] IF_PC;
  logic [31:0] IF_INSTR;
`ifdef LEVE1_IF_PERF_EN
  logic [31:0] PERF_FETCH;
  logic [31:0] PERF_DROP;
`endif

  leve1_if #(.XLEN(32), .RESET_PC(32'h8000_0000), .DEPTH(4)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .REDIRECT       (REDIRECT),
    .REDIRECT_PC    (REDIRECT_PC),
    .IMEM_REQ_VALID (IMEM_REQ_VALID),
    .IMEM_REQ_READY (IMEM_REQ_READY),
    .IMEM_REQ_ADDR  (IMEM_REQ_ADDR),
    .IMEM_RSP_VALID (IMEM_RSP_VALID),
    .IMEM_RSP_DATA  (IMEM_RSP_DATA),
    .IF_VALID       (IF_VALID),
    .IF_READY       (IF_READY),
    .IF_PC          (IF_PC),
    .IF_INSTR       (IF_INSTR)
`ifdef LEVE1_IF_PERF_EN
    ,
    .PERF_FETCH     (PERF_FETCH),
    .PERF_DROP      (PERF_DROP)
`endif
  );

  always #5 CLK = ~CLK;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  int unsigned lat     = 1;
  int unsigned n_fetch = 0;
  int unsigned n_req   = 0;
  int unsigned f0, r0;
  logic [31:0] exp_pc;
  logic [31:0] q_addr [$];
  int unsigned q_due  [$];

  logic        obs_req_valid, obs_if_valid;
  logic [31:0] obs_req_addr, obs_if_pc, obs_if_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h0000_0013;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs and memory response, observe, then advance past the edge.
  task automatic step(input logic redir, input logic [31:0] rpc, input logic if_rdy,
                      input logic req_rdy);
    REDIRECT       = redir;
    REDIRECT_PC    = rpc;
    IF_READY       = if_rdy;
    IMEM_REQ_READY = req_rdy;
    if (q_due.size() > 0 && q_due[0] <= cyc) begin
      IMEM_RSP_VALID = 1'b1;
      IMEM_RSP_DATA  = mem_word(q_addr[0]);
      void'(q_due.pop_front());
      void'(q_addr.pop_front());
    end else begin
      IMEM_RSP_VALID = 1'b0;
      IMEM_RSP_DATA  = '0;
    end
    #1;
    obs_req_valid = IMEM_REQ_VALID;
    obs_req_addr  = IMEM_REQ_ADDR;
    obs_if_valid  = IF_VALID;
    obs_if_pc     = IF_PC;
    obs_if_instr  = IF_INSTR;
    if (IMEM_REQ_VALID && IMEM_REQ_READY) begin
      q_addr.push_back(IMEM_REQ_ADDR);
      q_due.push_back(cyc + lat);
      n_req++;
    end
    if (IF_VALID && IF_READY) begin
      check("if_pc", 64'(IF_PC), 64'(exp_pc));
      check("if_instr", 64'(IF_INSTR), 64'(mem_word(exp_pc)));
      exp_pc = exp_pc + 32'd4;
      n_fetch++;
    end
    if (redir) exp_pc = {rpc[31:2], 2'b00};
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    RST            = 1'b1;
    REDIRECT       = 1'b0;
    REDIRECT_PC    = '0;
    IF_READY       = 1'b0;
    IMEM_REQ_READY = 1'b0;
    IMEM_RSP_VALID = 1'b0;
    IMEM_RSP_DATA  = '0;
    q_addr.delete();
    q_due.delete();
    #1;
    check("rst_req_valid", 64'(IMEM_REQ_VALID), 64'(0));
    check("rst_if_valid", 64'(IF_VALID), 64'(0));
    check("rst_if_pc", 64'(IF_PC), 64'(0));
    check("rst_if_instr", 64'(IF_INSTR), 64'(0));
    repeat (3) begin
      @(posedge CLK);
      #1;
    end
    RST    = 1'b0;
    exp_pc = 32'h8000_0000;
`ifdef LEVE1_IF_PERF_EN
    check("rst_perf_fetch", 64'(PERF_FETCH), 64'(0));
    check("rst_perf_drop", 64'(PERF_DROP), 64'(0));
`endif
  endtask

  initial begin
    // Boot and streaming with 1-cycle memory
    lat = 1;
    do_reset();
    step(1'b0, '0, 1'b1, 1'b1);
    check("boot_req_valid", 64'(obs_req_valid), 64'(0));
    check("boot_if_valid", 64'(obs_if_valid), 64'(0));
    step(1'b0, '0, 1'b1, 1'b1);
    check("first_req_valid", 64'(obs_req_valid), 64'(1));
    check("first_req_addr", 64'(obs_req_addr), 64'(32'h8000_0000));
    check("first_if_valid", 64'(obs_if_valid), 64'(0));
    step(1'b0, '0, 1'b1, 1'b1);
    check("no_bypass", 64'(obs_if_valid), 64'(0));
    f0 = n_fetch;
    repeat (12) step(1'b0, '0, 1'b1, 1'b1);
    check("stream_count", 64'(n_fetch - f0), 64'(12));
    check("stream_pc", 64'(exp_pc), 64'(32'h8000_0030));

    // Backpressure: credit stops requests at DEPTH, head held
    do_reset();
    r0 = n_req;
    repeat (12) step(1'b0, '0, 1'b0, 1'b1);
    check("bp_req_count", 64'(n_req - r0), 64'(4));
    check("bp_req_valid", 64'(obs_req_valid), 64'(0));
    check("bp_if_valid", 64'(obs_if_valid), 64'(1));
    check("bp_if_pc", 64'(obs_if_pc), 64'(32'h8000_0000));
    check("bp_if_instr", 64'(obs_if_instr), 64'(mem_word(32'h8000_0000)));
    f0 = n_fetch;
    step(1'b0, '0, 1'b1, 1'b1);
    check("bp_no_early_credit", 64'(obs_req_valid), 64'(0));
    step(1'b0, '0, 1'b1, 1'b1);
    check("bp_credit_back", 64'(obs_req_valid), 64'(1));
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    check("bp_drain", 64'(n_fetch - f0), 64'(4));
    check("bp_drain_pc", 64'(exp_pc), 64'(32'h8000_0010));

    // Redirect with 2 outstanding and 1 buffered, 3-cycle memory
    lat = 3;
    do_reset();
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    check("req_hold_addr", 64'(obs_req_addr), 64'(32'h8000_0004));
    step(1'b0, '0, 1'b0, 1'b1);
    check("req_hold_valid", 64'(obs_req_valid), 64'(1));
    step(1'b0, '0, 1'b0, 1'b1);
    f0 = n_fetch;
    step(1'b1, 32'h8000_0102, 1'b0, 1'b0);
    check("redir_if_valid", 64'(obs_if_valid), 64'(0));
    check("redir_req_valid", 64'(obs_req_valid), 64'(0));
    step(1'b0, '0, 1'b1, 1'b1);
    check("redir_req_valid_next", 64'(obs_req_valid), 64'(1));
    check("redir_req_addr", 64'(obs_req_addr), 64'(32'h8000_0100));
    step(1'b0, '0, 1'b1, 1'b1);
    check("drop1_if_valid", 64'(obs_if_valid), 64'(0));
    step(1'b0, '0, 1'b1, 1'b1);
    check("drop2_if_valid", 64'(obs_if_valid), 64'(0));
    repeat (7) step(1'b0, '0, 1'b1, 1'b1);
    check("redir_fetch_count", 64'(n_fetch - f0), 64'(5));
    check("redir_pc", 64'(exp_pc), 64'(32'h8000_0114));
`ifdef LEVE1_IF_PERF_EN
    check("redir_perf_fetch", 64'(PERF_FETCH), 64'(5));
    check("redir_perf_drop", 64'(PERF_DROP), 64'(3));
`endif

    // Redirect together with a response and a ready pop, then wrap
    lat = 1;
    do_reset();
    repeat (5) step(1'b0, '0, 1'b1, 1'b1);
    f0 = n_fetch;
    step(1'b1, 32'h8000_0200, 1'b1, 1'b1);
    check("sim_if_valid", 64'(obs_if_valid), 64'(0));
    check("sim_no_pop", 64'(n_fetch - f0), 64'(0));
    step(1'b0, '0, 1'b1, 1'b1);
    check("sim_req_addr", 64'(obs_req_addr), 64'(32'h8000_0200));
    check("sim_flushed", 64'(obs_if_valid), 64'(0));
    step(1'b0, '0, 1'b1, 1'b1);
    check("sim_rsp_no_bypass", 64'(obs_if_valid), 64'(0));
    step(1'b0, '0, 1'b1, 1'b1);
    check("sim_first_valid", 64'(obs_if_valid), 64'(1));
    check("sim_first_pc", 64'(obs_if_pc), 64'(32'h8000_0200));
`ifdef LEVE1_IF_PERF_EN
    check("sim_perf_fetch", 64'(PERF_FETCH), 64'(3));
    check("sim_perf_drop", 64'(PERF_DROP), 64'(2));
`endif
    step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    check("wrap_req_addr0", 64'(obs_req_addr), 64'(32'hFFFF_FFFC));
    step(1'b0, '0, 1'b1, 1'b1);
    check("wrap_req_addr1", 64'(obs_req_addr), 64'(32'h0000_0000));
    repeat (3) step(1'b0, '0, 1'b1, 1'b1);
    check("wrap_pc", 64'(exp_pc), 64'(32'h0000_0008));
`ifdef LEVE1_IF_PERF_EN
    check("wrap_perf_fetch", 64'(PERF_FETCH), 64'(6));
    check("wrap_perf_drop", 64'(PERF_DROP), 64'(4));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
